// File: rtl/mips_control_fsm.sv
// rtl/mips_control_fsm.sv - multi-cycle MIPS main controller (FETCH-DECODE-EXEC-MEM-WB)
module mips_control_fsm #(
    parameter int COUNT_W         = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    output logic               pc_en,
    output logic               branch,
    output logic               jump,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               alu_src,
    output logic [3:0]         alu_ctrl,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [2:0]         state,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        K_ILL, K_NOP, K_RALU, K_IALU, K_BEQ, K_J, K_LW, K_SW
    } kind_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t     state_q;
    logic [5:0] ir_op;
    logic [5:0] ir_func;
    kind_t      kind;
    logic [3:0] r_alu;

    assign state = state_q;

    // Decode works only on the latched IR so live fetch fields cannot leak past FETCH.
    always_comb begin
        kind  = K_ILL;
        r_alu = ALU_ADD;
        case (ir_op)
            6'h00: begin
                case (ir_func)
                    6'h20, 6'h21: kind = K_RALU;
                    6'h22: begin kind = K_RALU; r_alu = ALU_SUB; end
                    6'h24: begin kind = K_RALU; r_alu = ALU_AND; end
                    6'h25: begin kind = K_RALU; r_alu = ALU_OR;  end
                    6'h2A: begin kind = K_RALU; r_alu = ALU_SLT; end
                    6'h00: kind = K_NOP;
                    default: kind = K_ILL;
                endcase
            end
            6'h08, 6'h09: kind = K_IALU;
            6'h04:        kind = K_BEQ;
            6'h02:        kind = K_J;
            6'h23:        kind = K_LW;
            6'h2B:        kind = K_SW;
            default:      kind = K_ILL;
        endcase
    end

    always_comb begin
        pc_en      = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = ALU_AND;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH:  ir_write = 1'b1;
                S_DECODE: pc_en = (kind == K_ILL) && !HALT_ON_ILLEGAL;
                S_EXEC: begin
                    case (kind)
                        K_BEQ: begin branch = 1'b1; pc_en = 1'b1; alu_ctrl = ALU_SUB; end
                        K_J:   begin jump = 1'b1; pc_en = 1'b1; end
                        K_NOP: pc_en = 1'b1;
                        K_RALU: begin reg_dst = 1'b1; alu_ctrl = r_alu; end
                        K_IALU, K_LW, K_SW: begin alu_src = 1'b1; alu_ctrl = ALU_ADD; end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    alu_src  = 1'b1;
                    alu_ctrl = ALU_ADD;
                    if (kind == K_SW) begin
                        mem_write = 1'b1;
                        pc_en     = 1'b1;
                    end else begin
                        mem_read = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_en     = 1'b1;
                    if (kind == K_LW) begin
                        mem_to_reg = 1'b1;
                    end else if (kind == K_RALU) begin
                        reg_dst  = 1'b1;
                        alu_ctrl = r_alu;
                    end else begin
                        alu_src  = 1'b1;
                        alu_ctrl = ALU_ADD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            ir_op       <= 6'd0;
            ir_func     <= 6'd0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            if (pc_en)
                instr_count <= instr_count + COUNT_W'(1);
            case (state_q)
                S_FETCH: begin
                    ir_op   <= op;
                    ir_func <= func;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (kind == K_ILL) begin
                        illegal <= 1'b1;
                        state_q <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (kind)
                        K_RALU, K_IALU: state_q <= S_WB;
                        K_LW, K_SW:     state_q <= S_MEM;
                        default:        state_q <= S_FETCH;
                    endcase
                end
                S_MEM:   state_q <= (kind == K_LW) ? S_WB : S_FETCH;
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule
